// File: rtl/bp_be_pkg.sv
// bp_be_pkg
// Shared definitions for the back-end fe_queue buffer slice.
//
// Contents:
//   BSG_SAFE_CLOG2(x)                log2 that never returns 0 (returns 1 for x == 1)
//   BP_BE_FE_QUEUE_PTR_WIDTH(els)    pointer width: index bits plus one wrap bit
//   bp_be_fe_queue_els_gp            default entry count
//   bp_be_fe_queue_width_gp          default packet width (derived from core-if widths)
//   bp_be_fe_queue_ptr_t             pointer type for the default entry count
//
// Optional feature macro used by the files importing this package:
//   BP_BE_FE_QUEUE_ROLLBACK_EN  keeps entries resident until commit so the
//                               read pointer can be rolled back

`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

`define BP_BE_FE_QUEUE_PTR_WIDTH(els) (`BSG_SAFE_CLOG2(els) + 1)

package bp_be_pkg;

  // Default geometry; the packet width stands in for the value derived
  // from the core-interface packet structs.
  localparam int bp_be_fe_queue_els_gp       = 8;
  localparam int bp_be_fe_queue_width_gp     = 64;
  localparam int bp_be_fe_queue_ptr_width_gp = `BP_BE_FE_QUEUE_PTR_WIDTH(bp_be_fe_queue_els_gp);

  // MSB is the wrap bit, the low bits index storage.
  typedef logic [bp_be_fe_queue_ptr_width_gp-1:0] bp_be_fe_queue_ptr_t;

endpackage

// File: rtl/bp_be_fe_queue_mem.sv
// bp_be_fe_queue_mem
// Register file backing the fe_queue buffer: els_p entries of width_p bits,
// one synchronous write port and one asynchronous (combinational) read port.
// Contents are never reset.
//
// Ports:
//   clk_i     clock, write happens on the rising edge
//   w_v_i     write enable
//   w_addr_i  write index
//   w_data_i  write data
//   r_addr_i  read index
//   r_data_o  read data, combinational from r_addr_i

module bp_be_fe_queue_mem
  import bp_be_pkg::*;
 #(parameter int width_p      = bp_be_fe_queue_width_gp,
   parameter int els_p        = bp_be_fe_queue_els_gp,
   localparam int addr_width_lp = `BSG_SAFE_CLOG2(els_p))
  (input  logic                     clk_i,
   input  logic                     w_v_i,
   input  logic [addr_width_lp-1:0] w_addr_i,
   input  logic [width_p-1:0]       w_data_i,
   input  logic [addr_width_lp-1:0] r_addr_i,
   output logic [width_p-1:0]       r_data_o);

  logic [width_p-1:0] mem_q [els_p];

  // Storage write; no reset so the array maps onto plain flops or a
  // latch-free register file.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_buffer.sv
// bp_be_fe_queue_buffer
// Speculative FIFO between the front-end fe_queue producer and the back-end
// scheduler. Packets are handed out in order; with rollback enabled they stay
// resident after being read until committed, so the read pointer can be moved
// back to the commit pointer on a mispredict or exception. clr_v_i empties the
// buffer in one cycle.
//
// Configuration macro:
//   BP_BE_FE_QUEUE_ROLLBACK_EN  defined: commit pointer, deq_v_i and roll_v_i active
//                               undefined: a yumi frees its entry directly,
//                               deq_v_i and roll_v_i are ignored
//
// Ports:
//   clk_i, reset_i         clock, asynchronous active-high reset
//   fe_queue_i/_v_i        packet in, valid
//   fe_queue_ready_o       space available (depends only on registered pointers)
//   fe_queue_o/_v_o        packet at read pointer, unread entry present
//   fe_queue_yumi_i        scheduler consumes fe_queue_o
//   deq_v_i                commit oldest read entry
//   roll_v_i               read pointer returns to commit pointer
//   clr_v_i                discard all entries
//   empty_o                nothing resident at all

module bp_be_fe_queue_buffer
  import bp_be_pkg::*;
 #(parameter int fe_queue_width_p = bp_be_fe_queue_width_gp,
   parameter int els_p            = bp_be_fe_queue_els_gp,
   localparam int ptr_width_lp    = `BP_BE_FE_QUEUE_PTR_WIDTH(els_p))
  (input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [fe_queue_width_p-1:0] fe_queue_i,
   input  logic                        fe_queue_v_i,
   output logic                        fe_queue_ready_o,
   output logic [fe_queue_width_p-1:0] fe_queue_o,
   output logic                        fe_queue_v_o,
   input  logic                        fe_queue_yumi_i,
   input  logic                        deq_v_i,
   input  logic                        roll_v_i,
   input  logic                        clr_v_i,
   output logic                        empty_o);

  localparam int idx_width_lp = ptr_width_lp - 1;
  localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);

  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [ptr_width_lp-1:0] base_ptr;
  logic                    full;
  logic                    enq_v;

`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
  logic [ptr_width_lp-1:0] cptr_q, cptr_d;
  assign base_ptr = cptr_q;
`else
  // Without rollback a read frees its entry, so space is measured from rptr.
  logic unused_rollback_inputs;
  assign unused_rollback_inputs = deq_v_i ^ roll_v_i;
  assign base_ptr = rptr_q;
`endif

  // Same index with different wrap bits means the producer has lapped the
  // oldest resident entry.
  assign full = (wptr_q[idx_width_lp-1:0] == base_ptr[idx_width_lp-1:0])
              & (wptr_q[ptr_width_lp-1]   != base_ptr[ptr_width_lp-1]);

  assign fe_queue_ready_o = ~full;
  assign enq_v            = fe_queue_v_i & fe_queue_ready_o;
  assign fe_queue_v_o     = (rptr_q != wptr_q);
  assign empty_o          = (base_ptr == wptr_q);

  // Next-state pointer logic. Clear overrides everything; rollback overrides
  // yumi on the read pointer and lands on the commit pointer after any commit
  // happening in the same cycle.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
    cptr_d = cptr_q;
`endif
    if (clr_v_i) begin
      wptr_d = '0;
      rptr_d = '0;
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
      cptr_d = '0;
`endif
    end else begin
      if (enq_v) begin
        wptr_d = wptr_q + ptr_one_lp;
      end
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
      if (deq_v_i) begin
        cptr_d = cptr_q + ptr_one_lp;
      end
      if (roll_v_i) begin
        rptr_d = cptr_d;
      end else if (fe_queue_yumi_i) begin
        rptr_d = rptr_q + ptr_one_lp;
      end
`else
      if (fe_queue_yumi_i) begin
        rptr_d = rptr_q + ptr_one_lp;
      end
`endif
    end
  end

  // Pointer registers; only these are reset, storage contents are abandoned.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
      cptr_q <= '0;
`endif
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
      cptr_q <= cptr_d;
`endif
    end
  end

  // Caller protocol: yumi only with a valid packet, commit only a read entry.
  always @(posedge clk_i) begin
    if (!reset_i && !clr_v_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_v_o));
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
      assert (!(deq_v_i && (cptr_q == rptr_q)));
`endif
    end
  end

  bp_be_fe_queue_mem
   #(.width_p(fe_queue_width_p)
    ,.els_p  (els_p))
   mem
    (.clk_i   (clk_i)
    ,.w_v_i   (enq_v & ~clr_v_i)
    ,.w_addr_i(wptr_q[idx_width_lp-1:0])
    ,.w_data_i(fe_queue_i)
    ,.r_addr_i(rptr_q[idx_width_lp-1:0])
    ,.r_data_o(fe_queue_o));

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
// tb_bp_be_fe_queue_buffer
// Self-checking bench for bp_be_fe_queue_buffer with els_p = 4. A reference
// model keeps the resident packets in a queue (oldest committed-candidate
// first) plus a count of how many of them have been read speculatively.
// Follows BP_BE_FE_QUEUE_ROLLBACK_EN the same way the design does.

module tb_bp_be_fe_queue_buffer;

  localparam int ElsP   = 4;
  localparam int WidthP = 16;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [WidthP-1:0] fe_queue_i = '0;
  logic              fe_queue_v_i = 1'b0;
  logic              fe_queue_ready_o;
  logic [WidthP-1:0] fe_queue_o;
  logic              fe_queue_v_o;
  logic              fe_queue_yumi_i = 1'b0;
  logic              deq_v_i = 1'b0;
  logic              roll_v_i = 1'b0;
  logic              clr_v_i = 1'b0;
  logic              empty_o;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: resident packets and number already read.
  logic [WidthP-1:0] modelQ[$];
  int                modelRd = 0;

  bp_be_fe_queue_buffer
   #(.fe_queue_width_p(WidthP)
    ,.els_p(ElsP))
   dut
    (.clk_i(clk_i)
    ,.reset_i(reset_i)
    ,.fe_queue_i(fe_queue_i)
    ,.fe_queue_v_i(fe_queue_v_i)
    ,.fe_queue_ready_o(fe_queue_ready_o)
    ,.fe_queue_o(fe_queue_o)
    ,.fe_queue_v_o(fe_queue_v_o)
    ,.fe_queue_yumi_i(fe_queue_yumi_i)
    ,.deq_v_i(deq_v_i)
    ,.roll_v_i(roll_v_i)
    ,.clr_v_i(clr_v_i)
    ,.empty_o(empty_o));

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk_i = ~clk_i;

  // Expected outputs derived from the model's occupancy.
  function automatic logic expReady();
    return modelQ.size() < ElsP;
  endfunction

  function automatic logic expValid();
    return modelRd < modelQ.size();
  endfunction

  function automatic logic expEmpty();
    return modelQ.size() == 0;
  endfunction

  function automatic logic [WidthP-1:0] expData();
    if (modelRd < modelQ.size()) return modelQ[modelRd];
    return '0;
  endfunction

  // Drives one cycle of inputs from a negedge, lets the edge happen, moves
  // the model forward by the same rules and returns at the next negedge with
  // inputs idle.
  task automatic applyStimulus(input logic enq, input logic [WidthP-1:0] data,
                               input logic yumi, input logic deq,
                               input logic roll, input logic clr);
    logic accept;
    fe_queue_v_i    = enq;
    fe_queue_i      = data;
    fe_queue_yumi_i = yumi;
    deq_v_i         = deq;
    roll_v_i        = roll;
    clr_v_i         = clr;
    accept          = enq && expReady();
    @(posedge clk_i);
    if (clr) begin
      modelQ.delete();
      modelRd = 0;
    end else begin
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
      if (deq) begin
        void'(modelQ.pop_front());
        modelRd--;
      end
      if (roll) modelRd = 0;
      else if (yumi) modelRd++;
`else
      if (yumi) void'(modelQ.pop_front());
`endif
      if (accept) modelQ.push_back(data);
    end
    @(negedge clk_i);
    fe_queue_v_i    = 1'b0;
    fe_queue_yumi_i = 1'b0;
    deq_v_i         = 1'b0;
    roll_v_i        = 1'b0;
    clr_v_i         = 1'b0;
  endtask

  // Flags straight out of reset.
  task automatic test_reset();
    reset_i = 1'b1;
    @(negedge clk_i);
    assertCount++;
    if (fe_queue_ready_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL reset_ready: got %0b want 1", fe_queue_ready_o);
    end
    assertCount++;
    if (fe_queue_v_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_valid: got %0b want 0", fe_queue_v_o);
    end
    assertCount++;
    if (empty_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL reset_empty: got %0b want 1", empty_o);
    end
    reset_i = 1'b0;
    modelQ.delete();
    modelRd = 0;
    @(negedge clk_i);
  endtask

  // Fill A..D back to back, then offer a fifth packet that must be held off.
  task automatic test_fill();
    logic [WidthP-1:0] pkts [4] = '{16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3};
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      assertCount++;
      if (fe_queue_ready_o !== 1'b1) begin
        failCount++; $display("[TB] FAIL fill_ready_%0d: got %0b want 1", i, fe_queue_ready_o);
      end
      applyStimulus(1'b1, pkts[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    assertCount++;
    if (fe_queue_ready_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL fill_full_ready: got %0b want 0", fe_queue_ready_o);
    end
    assertCount++;
    if (empty_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL fill_empty: got %0b want 0", empty_o);
    end
    applyStimulus(1'b1, 16'hEEEE, 1'b0, 1'b0, 1'b0, 1'b0);
    assertCount++;
    if (fe_queue_ready_o !== 1'b0 || modelQ.size() != 4) begin
      failCount++; $display("[TB] FAIL fifth_held_ready: got %0b want 0", fe_queue_ready_o);
    end
    assertCount++;
    if (fe_queue_o !== 16'hA0A0 || fe_queue_v_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL fifth_held_head: got %h/%0b want a0a0/1", fe_queue_o, fe_queue_v_o);
    end
  endtask

`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
  // Read two packets, roll back, then commit one and roll back again.
  task automatic test_rollback();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    assertCount++;
    if (fe_queue_v_o !== 1'b0 || empty_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL all_read_flags: got v=%0b e=%0b want v=0 e=0", fe_queue_v_o, empty_o);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    assertCount++;
    if (fe_queue_o !== 16'h000A || fe_queue_v_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL roll_to_a: got %h/%0b want 000a/1", fe_queue_o, fe_queue_v_o);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    assertCount++;
    if (fe_queue_o !== 16'h000B || fe_queue_v_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL roll_to_b: got %h/%0b want 000b/1", fe_queue_o, fe_queue_v_o);
    end
    assertCount++;
    if (fe_queue_o !== expData()) begin
      failCount++; $display("[TB] FAIL roll_model: got %h want %h", fe_queue_o, expData());
    end
  endtask
`else
  // Without rollback a yumi frees space and roll_v_i has no effect.
  task automatic test_no_rollback();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, WidthP'(16'h0100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    assertCount++;
    if (fe_queue_ready_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL yumi_frees: got %0b want 1", fe_queue_ready_o);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    assertCount++;
    if (fe_queue_o !== 16'h0101 || fe_queue_v_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL roll_ignored: got %h/%0b want 0101/1", fe_queue_o, fe_queue_v_o);
    end
  endtask
`endif

  // Space comes back one cycle after the freeing operation; the next
  // packet wraps into index 0.
  task automatic test_wrap();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, WidthP'(16'h0200 + i), 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    deq_v_i = 1'b1;
`else
    fe_queue_yumi_i = 1'b1;
`endif
    #1;
    assertCount++;
    if (fe_queue_ready_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL ready_same_cycle: got %0b want 0", fe_queue_ready_o);
    end
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
`else
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    assertCount++;
    if (fe_queue_ready_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL ready_next_cycle: got %0b want 1", fe_queue_ready_o);
    end
    applyStimulus(1'b1, 16'hE0E0, 1'b0, 1'b0, 1'b0, 1'b0);
    while (modelQ[modelRd] !== 16'hE0E0) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    assertCount++;
    if (fe_queue_o !== 16'hE0E0 || fe_queue_v_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL wrap_entry: got %h/%0b want e0e0/1", fe_queue_o, fe_queue_v_o);
    end
  endtask

  // Clear wins over everything issued alongside it.
  task automatic test_clear();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3333, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h4444, 1'b1, 1'b1, 1'b0, 1'b1);
    assertCount++;
    if (fe_queue_v_o !== 1'b0 || empty_o !== 1'b1 || fe_queue_ready_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL clear_flags: got v=%0b e=%0b r=%0b want 0/1/1", fe_queue_v_o, empty_o, fe_queue_ready_o);
    end
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    assertCount++;
    if (fe_queue_o !== 16'h5555 || fe_queue_v_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL clear_restart: got %h/%0b want 5555/1", fe_queue_o, fe_queue_v_o);
    end
  endtask

  // Reset in the middle of a cycle drops the flags before the next edge.
  task automatic test_async_reset();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, WidthP'(16'h0300 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset_i = 1'b1;
    #1;
    assertCount++;
    if (fe_queue_v_o !== 1'b0 || empty_o !== 1'b1 || fe_queue_ready_o !== 1'b1) begin
      failCount++; $display("[TB] FAIL async_reset: got v=%0b e=%0b r=%0b want 0/1/1", fe_queue_v_o, empty_o, fe_queue_ready_o);
    end
    modelQ.delete();
    modelRd = 0;
    @(negedge clk_i);
    reset_i = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    assertCount++;
    if (fe_queue_v_o !== 1'b0) begin
      failCount++; $display("[TB] FAIL stale_after_reset: got %0b want 0", fe_queue_v_o);
    end
    applyStimulus(1'b1, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
    assertCount++;
    if (fe_queue_o !== 16'h0F0F) begin
      failCount++; $display("[TB] FAIL first_after_reset: got %h want 0f0f", fe_queue_o);
    end
  endtask

  // Random traffic against the model, legal yumi/commit only.
  task automatic test_random();
    logic enq, yumi, deq, roll, clr;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      assertCount++;
      if (fe_queue_ready_o !== expReady()) begin
        failCount++; $display("[TB] FAIL rand_ready@%0d: got %0b want %0b", cyc, fe_queue_ready_o, expReady());
      end
      assertCount++;
      if (fe_queue_v_o !== expValid()) begin
        failCount++; $display("[TB] FAIL rand_valid@%0d: got %0b want %0b", cyc, fe_queue_v_o, expValid());
      end
      assertCount++;
      if (empty_o !== expEmpty()) begin
        failCount++; $display("[TB] FAIL rand_empty@%0d: got %0b want %0b", cyc, empty_o, expEmpty());
      end
      if (expValid()) begin
        assertCount++;
        if (fe_queue_o !== expData()) begin
          failCount++; $display("[TB] FAIL rand_data@%0d: got %h want %h", cyc, fe_queue_o, expData());
        end
      end
      enq  = ($urandom_range(3) != 0);
      yumi = expValid() && ($urandom_range(2) != 0);
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
      deq  = (modelRd > 0) && ($urandom_range(1) != 0);
`else
      deq  = ($urandom_range(1) != 0);
`endif
      roll = ($urandom_range(11) == 0);
      clr  = ($urandom_range(39) == 0);
      applyStimulus(enq, WidthP'($urandom), yumi, deq, roll, clr);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
`ifdef BP_BE_FE_QUEUE_ROLLBACK_EN
    test_rollback();
`else
    test_no_rollback();
`endif
    test_wrap();
    test_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/bp_be_fe_queue_buffer.md
# bp_be_fe_queue_buffer

Speculative FIFO between the front end's fe_queue producer and the back end's scheduler. It buffers fetched-instruction/exception packets and hands them to the scheduler in order. Entries stay resident after the scheduler reads them until commit, so a mispredict or exception can roll the read pointer back without refetching. Flush clears all contents in one cycle.

## Interface
- fe_queue_width_p, 0 (derived from core-if widths), width of one fe_queue packet
- els_p, 8, entry count; power of two, >= 2
- ptr_width_lp, `BSG_SAFE_CLOG2(els_p)+1`, pointer width including wrap bit

- clk_i  in  1  clock, all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- fe_queue_i  in  fe_queue_width_p  packet from front end
- fe_queue_v_i  in  1  packet valid
- fe_queue_ready_o  out  1  space available (ready-valid, enqueue when v & ready)
- fe_queue_o  out  fe_queue_width_p  packet at read pointer
- fe_queue_v_o  out  1  unread entry present
- fe_queue_yumi_i  in  1  scheduler consumes fe_queue_o this cycle; legal only when fe_queue_v_o
- deq_v_i  in  1  commit: free oldest read entry
- roll_v_i  in  1  rollback: read pointer := commit pointer
- clr_v_i  in  1  flush: discard all entries
- empty_o  out  1  no entries resident (committed or not)

## Operation
- Three pointers, each ptr_width_lp bits, low bits index storage, MSB is wrap bit: wptr (enqueue), rptr (speculative read), cptr (commit).
- Enqueue: fe_queue_v_i & fe_queue_ready_o -> write mem[wptr], wptr+1.
- Read: fe_queue_yumi_i -> rptr+1.
- Commit: deq_v_i -> cptr+1. Caller guarantees cptr != rptr; violation is an assertion failure.
- Rollback: roll_v_i -> rptr := cptr (after any same-cycle commit, i.e. rptr := cptr+deq_v_i).
- Clear: clr_v_i -> wptr=rptr=cptr=0; same-cycle enqueue, yumi, deq, roll discarded.
- Priority: clr_v_i > roll_v_i > fe_queue_yumi_i for rptr; enqueue and commit independent of read.
- full = (wptr[low] == cptr[low]) & (wptr[MSB] != cptr[MSB]); fe_queue_ready_o = ~full.
- fe_queue_v_o = (rptr != wptr); empty_o = (cptr == wptr).
- All pointer arithmetic modulo 2^ptr_width_lp; wrap-around natural.
- Storage contents not reset; only pointers reset.

## Timing
- Reset (async assert): all pointers 0 -> fe_queue_ready_o=1, fe_queue_v_o=0, empty_o=1; fe_queue_o undefined.
- Enqueue-to-visible latency: 1 cycle (written on edge N, fe_queue_v_o high after edge N).
- fe_queue_o combinational from storage at rptr; no ready-to-valid combinational path.
- fe_queue_ready_o depends only on registered pointers; commit frees space one cycle later.
- Full and yumi same cycle: enqueue still blocked (space freed only by commit).
- Empty and enqueue same cycle: fe_queue_v_o stays 0 that cycle (no bypass).
- Reset asserted mid-operation: pointers cleared immediately, contents abandoned.

## Configuration
- BP_BE_FE_QUEUE_ROLLBACK_EN defined: behaviour above.
- Not defined: cptr removed; yumi frees entry directly; deq_v_i and roll_v_i ignored; full computed from rptr; empty_o = ~fe_queue_v_o.

## Structure
- Pointer typedef and `bp_be_fe_queue_ptr_width(els)` macro in bp_be_pkg.
- Sub-module bp_be_fe_queue_mem: els_p x fe_queue_width_p, 1 sync write, 1 async read register file.
- Pointer logic and status flags in top module.

## Test plan
- els_p=4: enqueue A,B,C,D back-to-back -> ready_o low after D; fifth packet held off; empty_o=0.
- Enqueue A,B; yumi A,B; roll_v_i -> fe_queue_o=A, v_o=1 next cycle; yumi A, deq_v_i, roll -> fe_queue_o=B.
- Fill 4, yumi 4, deq 1 -> ready_o high next cycle, not same cycle; enqueue E lands at index 0 (wrap).
- clr_v_i with concurrent enqueue, yumi, deq -> all pointers 0, v_o=0, empty_o=1, ready_o=1.
- Reset asserted asynchronously mid-stream with 3 entries -> v_o drops before next edge; no stale packet afterward.
- Macro undefined: enqueue 4, yumi 1 -> ready_o high next cycle; roll_v_i ignored.
